signed_calc_seq: RTL

Parametrised, clocked successor to the 4-bit combinational signed calculator. It performs add, subtract, multiply or divide on two WIDTH-bit two's-complement operands. Add and subtract complete in one cycle; multiply and divide use an iterative shift-add / restoring-divide datapath under a start/busy/done handshake. It sits between the operand/mode input registers and the display/output stage, and keeps the existing mode encoding and the quotient-low / remainder-high output packing.

---
 rtl/signed_calc_seq_if.sv | 36 +++
 rtl/signed_calc_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/signed_calc_seq_if.sv
// signed_calc_seq_if
//   Request/result bundle for the sequential signed calculator.
//   Parameter: WIDTH - operand width (2..16).
//   Signals:
//     Start      request, accepted only when the calculator is idle
//     M[1:0]     mode: 00 add, 01 sub, 10 mult, 11 div
//     A, B       WIDTH-bit two's-complement operands, sampled with Start
//     Out        2*WIDTH-bit registered result
//     Busy       operation in progress
//     Done       one-cycle completion pulse
//     Err        divide by zero / divider not built
//     Ovf        quotient not representable
//   Modports: master drives the request side, slave is the calculator.
interface signed_calc_seq_if #(
    parameter int WIDTH = 4
);
    logic                   Start;
    logic [1:0]             M;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [2*WIDTH-1:0]     Out;
    logic                   Busy;
    logic                   Done;
    logic                   Err;
    logic                   Ovf;

    modport master (
        output Start, M, A, B,
        input  Out, Busy, Done, Err, Ovf
    );

    modport slave (
        input  Start, M, A, B,
        output Out, Busy, Done, Err, Ovf
    );
endinterface

// File: rtl/signed_calc_seq.sv
// signed_calc_seq
//   Clocked signed calculator: add/sub in one cycle, multiply by
//   shift-add and divide by restoring division, WIDTH iterations each.
//   Divide output packs quotient low, remainder high; remainder follows
//   the sign of A (truncation toward zero).
//   Parameter: WIDTH - operand width (2..16).
//   Ports:
//     Clk    rising-edge clock
//     Reset  synchronous active-high reset, clears all state and outputs
//     bus    signed_calc_seq_if.slave (Start, M, A, B -> Out, Busy, Done,
//            Err, Ovf)
//   Build option: define SIGNED_CALC_DIV_EN to build the divider; without
//   it, M=11 completes in one cycle with Out=0, Err=1.
module signed_calc_seq #(
    parameter int WIDTH = 4
) (
    input logic              Clk,
    input logic              Reset,
    signed_calc_seq_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mag_a;
    logic [2*WIDTH-1:0]   work;     // mult: {partial hi, multiplier}; div: {rem, dividend/quotient}
    logic [2*WIDTH-1:0]   res;
    logic                 res_sign;
    logic                 err_p;
    logic                 ovf_p;

    logic [WIDTH:0]       add_res;
    logic [WIDTH:0]       sub_res;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   mul_prod;

`ifdef SIGNED_CALC_DIV_EN
    logic [WIDTH-1:0]     mag_b;
    logic                 a_sign;
    logic                 op_div;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo_fixed;
    logic [WIDTH-1:0]     rem_fixed;
`endif

    always_comb begin
        add_res  = {bus.A[WIDTH-1], bus.A} + {bus.B[WIDTH-1], bus.B};
        sub_res  = {bus.A[WIDTH-1], bus.A} - {bus.B[WIDTH-1], bus.B};
        abs_a    = bus.A[WIDTH-1] ? ('0 - bus.A) : bus.A;
        abs_b    = bus.B[WIDTH-1] ? ('0 - bus.B) : bus.B;
        // Right-shifting shift-add: add A into the high half when the
        // current multiplier LSB is set, then shift the whole pair.
        mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, mag_a} : '0);
        mul_next = {mul_sum, work[WIDTH-1:1]};
        mul_prod = res_sign ? ('0 - work) : work;
`ifdef SIGNED_CALC_DIV_EN
        // Restoring step: shift next dividend bit into the remainder and
        // keep the subtraction only if it did not go negative.
        div_trial = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        div_diff  = div_trial - {1'b0, mag_b};
        div_next  = div_diff[WIDTH]
                  ? {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0],  work[WIDTH-2:0], 1'b1};
        quo_fixed = res_sign ? ('0 - work[WIDTH-1:0]) : work[WIDTH-1:0];
        rem_fixed = a_sign ? ('0 - work[2*WIDTH-1:WIDTH]) : work[2*WIDTH-1:WIDTH];
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            mag_a    <= '0;
            work     <= '0;
            res      <= '0;
            res_sign <= 1'b0;
            err_p    <= 1'b0;
            ovf_p    <= 1'b0;
`ifdef SIGNED_CALC_DIV_EN
            mag_b    <= '0;
            a_sign   <= 1'b0;
            op_div   <= 1'b0;
`endif
            bus.Out  <= '0;
            bus.Busy <= 1'b0;
            bus.Done <= 1'b0;
            bus.Err  <= 1'b0;
            bus.Ovf  <= 1'b0;
        end else begin
            bus.Done <= 1'b0;
            case (state)
                IDLE: begin
                    // A Start coinciding with the Done pulse is dropped.
                    if (bus.Start && !bus.Done) begin
                        bus.Busy <= 1'b1;
                        err_p    <= 1'b0;
                        ovf_p    <= 1'b0;
                        cnt      <= '0;
                        res_sign <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        case (bus.M)
                            2'b00: begin
                                res   <= {{(WIDTH-1){add_res[WIDTH]}}, add_res};
                                state <= DONE;
                            end
                            2'b01: begin
                                res   <= {{(WIDTH-1){sub_res[WIDTH]}}, sub_res};
                                state <= DONE;
                            end
                            2'b10: begin
                                mag_a  <= abs_a;
                                work   <= {{WIDTH{1'b0}}, abs_b};
`ifdef SIGNED_CALC_DIV_EN
                                op_div <= 1'b0;
`endif
                                state  <= ITER;
                            end
                            default: begin
`ifdef SIGNED_CALC_DIV_EN
                                if (bus.B == '0) begin
                                    res   <= '0;
                                    err_p <= 1'b1;
                                    state <= DONE;
                                end else begin
                                    mag_b  <= abs_b;
                                    work   <= {{WIDTH{1'b0}}, abs_a};
                                    a_sign <= bus.A[WIDTH-1];
                                    op_div <= 1'b1;
                                    ovf_p  <= (bus.A == MIN_VAL) && (bus.B == '1);
                                    state  <= ITER;
                                end
`else
                                res   <= '0;
                                err_p <= 1'b1;
                                state <= DONE;
`endif
                            end
                        endcase
                    end
                end
                ITER: begin
`ifdef SIGNED_CALC_DIV_EN
                    if (op_div) work <= div_next;
                    else        work <= mul_next;
`else
                    work <= mul_next;
`endif
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= FIX;
                end
                FIX: begin
`ifdef SIGNED_CALC_DIV_EN
                    if (op_div) res <= {rem_fixed, quo_fixed};
                    else        res <= mul_prod;
`else
                    res <= mul_prod;
`endif
                    state <= DONE;
                end
                DONE: begin
                    bus.Out  <= res;
                    bus.Err  <= err_p;
                    bus.Ovf  <= ovf_p;
                    bus.Done <= 1'b1;
                    bus.Busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
